pellet_map: RTL

Pellet state store for the maze. Holds one pellet bit per tile, and one power-pellet bit per tile when that feature is compiled in. Sits directly upstream of the sprite register file:
- its `pellet_data` output feeds the register file's pellet-data read port;
- its `cpu_x`/`cpu_y`/`clear_req` inputs are driven from the register file's PelletX, PelletY and PelletClear registers.

It also serves a second read port to the tile renderer. It loads the level layout from a fixed ROM after reset and on refill, and tracks how many pellets remain.

---
 rtl/pacman_pkg.sv | 60 ++++++
 rtl/pellet_layout_rom.sv | 36 +++
 rtl/pellet_map.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared definitions for the maze blocks.
//   TILE_W       - width of one tile coordinate (x or y)
//   MAP_ADDR_W   - width of a tile address {y, x} (stride 32 per row)
//   map_state_t  - pellet_map controller states
//   PELLET_ART   - pellet layout of the 28x31 maze, one row per entry,
//                  bit index = tile x ('1' = pellet or power pellet)
//   tile_addr()  - builds the tile address from x/y
package pacman_pkg;

  localparam int TILE_W     = 5;
  localparam int MAP_ADDR_W = 10;
  localparam int ART_W      = 28;
  localparam int ART_H      = 31;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RMW  = 2'd2
  } map_state_t;

  localparam logic [0:ART_W-1] PELLET_ART [0:ART_H-1] = '{
    28'b0000000000000000000000000000,
    28'b0111111111111001111111111110,
    28'b0100001000001001000001000010,
    28'b0100001000001001000001000010,
    28'b0100001000001001000001000010,
    28'b0111111111111111111111111110,
    28'b0100001001000000001001000010,
    28'b0100001001000000001001000010,
    28'b0111111001111001111001111110,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0000001000000000000001000000,
    28'b0111111111111001111111111110,
    28'b0100001000001001000001000010,
    28'b0100001000001001000001000010,
    28'b0111001111111001111111001110,
    28'b0001001001000000001001001000,
    28'b0001001001000000001001001000,
    28'b0111111001111001111001111110,
    28'b0100000000001001000000000010,
    28'b0100000000001001000000000010,
    28'b0111111111111111111111111110,
    28'b0000000000000000000000000000
  };

  function automatic logic [MAP_ADDR_W-1:0] tile_addr(input logic [TILE_W-1:0] x,
                                                      input logic [TILE_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/pellet_layout_rom.sv
// pellet_layout_rom: combinational level-layout ROM.
//   addr  in  MAP_ADDR_W  tile address {y, x}
//   data  out 2           {power, pellet}; 0 for tiles outside the grid
// Power pellets sit in the four maze corners at (1,3), (26,3), (1,23), (26,23)
// and are also marked as ordinary pellets in the art.
module pellet_layout_rom
  import pacman_pkg::*;
#(
  parameter int GRID_W = 28,
  parameter int GRID_H = 31
) (
  input  logic [MAP_ADDR_W-1:0] addr,
  output logic [1:0]            data
);

  logic [TILE_W-1:0] x;
  logic [TILE_W-1:0] y;
  logic              in_range;
  logic              pellet;
  logic              power;

  always_comb begin
    x        = addr[TILE_W-1:0];
    y        = addr[MAP_ADDR_W-1:TILE_W];
    in_range = (int'(x) < GRID_W) && (int'(y) < GRID_H) &&
               (int'(x) < ART_W) && (int'(y) < ART_H);
    pellet   = 1'b0;
    power    = 1'b0;
    if (in_range) begin
      pellet = PELLET_ART[y][x];
      power  = ((x == 5'd1) || (x == 5'd26)) && ((y == 5'd3) || (y == 5'd23));
    end
    data = {power, pellet};
  end

endmodule

// File: rtl/pellet_map.sv
// pellet_map: pellet state store for the maze.
//   clk, reset        clock, synchronous active-high reset
//   cpu_x, cpu_y      CPU query / clear tile
//   clear_req         pulse: eat the pellet at (cpu_x, cpu_y)
//   refill_req        pulse: reload the layout for the next level
//   vid_x, vid_y      renderer tile
//   pellet_data       pellet at CPU tile (registered, 1 cycle)
//   vid_pellet        pellet at renderer tile (registered, 1 cycle)
//   eaten             pulse: a pellet was removed
//   remaining         pellets still present
//   level_clear       remaining == 0 and not busy
//   busy              layout load in progress
//   vid_power         power pellet at renderer tile   (PELLET_POWER_EN)
//   power_eaten       pulse with eaten for a power pellet (PELLET_POWER_EN)
//   state             controller state (LOAD / IDLE / RMW)
// Optional feature macro: PELLET_POWER_EN adds the power-pellet plane.
module pellet_map
  import pacman_pkg::*;
#(
  parameter int GRID_W       = 28,
  parameter int GRID_H       = 31,
  parameter int LAYOUT_COUNT = 244
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TILE_W-1:0]     cpu_x,
  input  logic [TILE_W-1:0]     cpu_y,
  input  logic                  clear_req,
  input  logic                  refill_req,
  input  logic [TILE_W-1:0]     vid_x,
  input  logic [TILE_W-1:0]     vid_y,
  output logic                  pellet_data,
  output logic                  vid_pellet,
  output logic                  eaten,
  output logic [MAP_ADDR_W-1:0] remaining,
  output logic                  level_clear,
  output logic                  busy,
`ifdef PELLET_POWER_EN
  output logic                  vid_power,
  output logic                  power_eaten,
`endif
  output map_state_t            state
);

  localparam int MAP_SIZE = 1 << MAP_ADDR_W;

  if (LAYOUT_COUNT >= MAP_SIZE) begin : g_count_check
    $error("pellet_map: LAYOUT_COUNT does not fit in remaining");
  end

  logic [MAP_ADDR_W-1:0] load_addr;
  logic [MAP_ADDR_W-1:0] rmw_addr;
  logic [1:0]            rom_data;
  logic                  rom_pellet;
  logic                  start_load;
  logic                  read_ok;
  logic                  cpu_in_range;
  logic                  vid_in_range;
  logic                  wr_en;
  logic [MAP_ADDR_W-1:0] wr_addr;
  logic                  wr_pellet;
  logic                  pel_ram [0:MAP_SIZE-1];

  pellet_layout_rom #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_rom (
    .addr (load_addr),
    .data (rom_data)
  );

  // A power tile is always a pellet tile, so it is stored and counted once.
  assign rom_pellet = |rom_data;

  // Requests: refill (or reset) always wins and restarts the load. clear_req is
  // taken only in IDLE with in-range coordinates; anywhere else it is dropped.
  always_comb begin
    start_load   = reset || refill_req;
    read_ok      = (state != ST_LOAD) && !refill_req;
    cpu_in_range = (int'(cpu_x) < GRID_W) && (int'(cpu_y) < GRID_H);
    vid_in_range = (int'(vid_x) < GRID_W) && (int'(vid_y) < GRID_H);
    wr_en        = 1'b0;
    wr_addr      = load_addr;
    wr_pellet    = rom_pellet;
    if (!start_load) begin
      if (state == ST_LOAD) begin
        wr_en = 1'b1;
      end else if (state == ST_RMW) begin
        // Clearing an already-empty tile is harmless, so write unconditionally.
        wr_en     = 1'b1;
        wr_addr   = rmw_addr;
        wr_pellet = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pel_ram[wr_addr] <= wr_pellet;
  end

`ifdef PELLET_POWER_EN
  logic pow_ram [0:MAP_SIZE-1];

  always_ff @(posedge clk) begin
    if (wr_en) pow_ram[wr_addr] <= wr_pellet & rom_data[1];
  end
`endif

  always_ff @(posedge clk) begin
    eaten <= 1'b0;
`ifdef PELLET_POWER_EN
    power_eaten <= 1'b0;
`endif
    if (start_load) begin
      state     <= ST_LOAD;
      load_addr <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (rom_pellet) remaining <= remaining + 1'b1;
          load_addr <= load_addr + 1'b1;
          if (load_addr == '1) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clear_req && cpu_in_range) begin
            rmw_addr <= tile_addr(cpu_x, cpu_y);
            state    <= ST_RMW;
          end
        end
        ST_RMW: begin
          if (pel_ram[rmw_addr]) begin
            eaten <= 1'b1;
            if (remaining != '0) remaining <= remaining - 1'b1;
`ifdef PELLET_POWER_EN
            power_eaten <= pow_ram[rmw_addr];
`endif
          end
          state <= ST_IDLE;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pellet_data <= 1'b0;
      vid_pellet  <= 1'b0;
`ifdef PELLET_POWER_EN
      vid_power   <= 1'b0;
`endif
    end else begin
      pellet_data <= read_ok & cpu_in_range & pel_ram[tile_addr(cpu_x, cpu_y)];
      vid_pellet  <= read_ok & vid_in_range & pel_ram[tile_addr(vid_x, vid_y)];
`ifdef PELLET_POWER_EN
      vid_power   <= read_ok & vid_in_range & pow_ram[tile_addr(vid_x, vid_y)];
`endif
    end
  end

  assign busy        = (state == ST_LOAD);
  assign level_clear = (remaining == '0) && !busy;

endmodule
